// File: rtl/pattern_seq_pkg.sv
// Shared types and helpers for the pattern_seq_rx phase-sequence monitor.
package pattern_seq_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_e;

    localparam int         PHASES        = 6;
    localparam logic [2:0] NO_PHASE      = 3'd7;
    localparam logic       CAUSE_ORDER   = 1'b0;
    localparam logic       CAUSE_ILLEGAL = 1'b1;

    function automatic logic [2:0] onehot_to_idx(input logic [5:0] code);
        logic [2:0] idx;
        idx = NO_PHASE;
        case (code)
            6'b000001: idx = 3'd0;
            6'b000010: idx = 3'd1;
            6'b000100: idx = 3'd2;
            6'b001000: idx = 3'd3;
            6'b010000: idx = 3'd4;
            6'b100000: idx = 3'd5;
            default:   idx = NO_PHASE;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] k);
        return (k == 3'(PHASES - 1)) ? 3'd0 : k + 3'd1;
    endfunction

endpackage

// File: rtl/pattern_seq_filter.sv
// Two-flop synchronizer plus stability filter; emits the accepted code and a
// one-cycle new-code pulse (combinational, so the top can register it).
module pattern_seq_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] lines_i,
    output logic [5:0] code_o,
    output logic       new_code_o
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [5:0] sync1_q, sync2_q;
    logic [5:0] cand_q, cand_d;
    logic [5:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       new_code;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        new_code = (cnt_q == STABLE) && (cand_q != acc_q);
        // A changed sample restarts the run; a steady one counts up and saturates.
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 4'd1;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (new_code) begin
            acc_d = cand_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= lines_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign code_o     = cand_q;
    assign new_code_o = new_code;

endmodule

// File: rtl/pattern_seq_rx.sv
// Phase-rotation monitor: FSM, dwell counter and registered tile outputs.
// Optional dwell timeout enabled by defining PATTERN_SEQ_RX_DWELL_CHECK_EN.
module pattern_seq_rx
    import pattern_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int LOCK_COUNT    = 2,
    parameter int MAX_DWELL     = 4095
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [11:0] DWELL_MAX = 12'(MAX_DWELL);
    localparam logic [2:0]  LOCK_N    = 3'(LOCK_COUNT);

    logic       clk, rst;
    logic [5:0] code;
    logic       new_code;
    logic [2:0] idx;
    logic       legal, in_order, timeout;

    state_e     state_q, state_d;
    logic [2:0] adv_q, adv_d;
    logic [2:0] phase_q, phase_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic       strobe_q, strobe_d;
    logic       cause_q, cause_d;
    logic       hb_q, hb_d;

    assign clk = io_in[0];
    assign rst = io_in[1];

    pattern_seq_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk_i      (clk),
        .rst_i      (rst),
        .lines_i    (io_in[7:2]),
        .code_o     (code),
        .new_code_o (new_code)
    );

    assign idx      = onehot_to_idx(code);
    assign legal    = (idx != NO_PHASE);
    assign in_order = legal && (idx == next_phase(phase_q));

`ifdef PATTERN_SEQ_RX_DWELL_CHECK_EN
    logic [11:0] dwell_q, dwell_d;

    always_comb begin
        dwell_d = dwell_q;
        if (new_code) begin
            dwell_d = '0;
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dwell_q <= '0;
        else     dwell_q <= dwell_d;
    end

    // An accepted change in the same cycle beats the timeout.
    assign timeout = (state_q == LOCKED) && (dwell_q == DWELL_MAX) && !new_code;
`else
    logic unused_dwell_max;
    assign unused_dwell_max = ^DWELL_MAX;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        adv_d    = adv_q;
        cause_d  = cause_q;
        phase_d  = phase_q;
        strobe_d = 1'b0;
        hb_d     = hb_q;
        if (new_code) begin
            phase_d = idx;
            if (legal) begin
                strobe_d = 1'b1;
                hb_d     = ~hb_q;
            end
        end
        case (state_q)
            HUNT: begin
                if (new_code && legal) begin
                    state_d = TRACK;
                    adv_d   = '0;
                end
            end
            TRACK: begin
                if (new_code) begin
                    if (in_order) begin
                        adv_d = adv_q + 3'd1;
                        if (adv_q + 3'd1 == LOCK_N) state_d = LOCKED;
                    end else begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (new_code) begin
                    if (!in_order) begin
                        state_d = ERROR;
                        cause_d = legal ? CAUSE_ORDER : CAUSE_ILLEGAL;
                    end
                end else if (timeout) begin
                    state_d = ERROR;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = HUNT;
        endcase
        locked_d = (state_d == LOCKED);
        err_d    = (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            adv_q    <= '0;
            phase_q  <= NO_PHASE;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            cause_q  <= 1'b0;
            hb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            adv_q    <= adv_d;
            phase_q  <= phase_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            cause_q  <= cause_d;
            hb_q     <= hb_d;
        end
    end

    assign io_out = {hb_q, cause_q, strobe_q, err_q, locked_q, phase_q};

endmodule

// File: tb/tb_pattern_seq_rx.sv
// Scoreboard bench for pattern_seq_rx: expected strobe outputs are queued by
// the stimulus and popped by a negedge monitor whenever the strobe is high.
module tb_pattern_seq_rx;

`ifdef PATTERN_SEQ_RX_DWELL_CHECK_EN
    localparam int TB_MAX_DWELL = 60;
`else
    localparam int TB_MAX_DWELL = 4095;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] lines = 6'b0;
    logic [7:0] io_out;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp, mon_mask;
    int         n_checks = 0;
    int         n_fail = 0;
    int         strobe_seen = 0;

    pattern_seq_rx #(
        .STABLE_CYCLES (4),
        .LOCK_COUNT    (2),
        .MAX_DWELL     (TB_MAX_DWELL)
    ) dut (
        .io_in  ({lines, rst, clk}),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && io_out[5]) begin
            strobe_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got io_out=%h, required no strobe", io_out);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_mask = mon_exp[4] ? 8'hFF : 8'hBF;
                if ((io_out & mon_mask) !== (mon_exp & mon_mask)) begin
                    n_fail++;
                    $display("FAIL strobe_out: got io_out=%h, required %h", io_out, mon_exp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] code, input logic [7:0] exp, input int hold = 50);
        exp_q.push_back(exp);
        lines = code;
        step(hold);
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", io_out, 8'h07);
        lines = 6'b0;
        step(3);
        rst = 1'b0;
        step(3);
    endtask

    int lat;
    int s0;
    logic found;

    initial begin
        step(3);
        check("reset_out", io_out, 8'h07);
        rst = 1'b0;
        step(10);
        check("idle_zero_code", io_out, 8'h07);

        // First phase: measure change-to-strobe latency.
        exp_q.push_back(8'hA0);
        lines = 6'b000001;
        lat = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (io_out[5]) begin
                found = 1'b1;
                lat = i;
            end
        end
        check_int("strobe_latency", lat, 7);
        step(43);
        check("after_first_phase", io_out, 8'h80);

        // Full rotation with wrap; locks on second advance.
        drive(6'b000010, 8'h21);
        drive(6'b000100, 8'hAA);
        drive(6'b001000, 8'h2B);
        drive(6'b010000, 8'hAC);
        drive(6'b100000, 8'h2D);
        drive(6'b000001, 8'hA8);
        check("wrapped_locked", io_out, 8'h88);
        drive(6'b000010, 8'h29);
        drive(6'b000100, 8'hAA);
        drive(6'b001000, 8'h2B);

        // Short glitch 3 -> 4 -> 3 must be invisible.
        s0 = strobe_seen;
        lines = 6'b010000;
        step(3);
        lines = 6'b001000;
        step(30);
        check_int("glitch_strobes", strobe_seen, s0);
        check("glitch_hold", io_out, 8'h0B);

        // Out-of-order 2 -> 4 while locked, then sticky error.
        drive(6'b010000, 8'hAC);
        drive(6'b100000, 8'h2D);
        drive(6'b000001, 8'hA8);
        drive(6'b000010, 8'h29);
        drive(6'b000100, 8'hAA);
        drive(6'b010000, 8'h34);
        drive(6'b100000, 8'hB5);
        drive(6'b000001, 8'h30);
        check("error_sticky", io_out, 8'h10);

        // Illegal multi-hot code while locked.
        do_reset();
        drive(6'b000001, 8'hA0);
        drive(6'b000010, 8'h21);
        drive(6'b000100, 8'hAA);
        lines = 6'b000011;
        step(10);
        check("illegal_code", io_out, 8'hD7);
        drive(6'b001000, 8'h73);
        check("error_phase_track", io_out, 8'h53);

`ifdef PATTERN_SEQ_RX_DWELL_CHECK_EN
        // Dwell timeout: hold a phase past MAX_DWELL while locked.
        do_reset();
        drive(6'b000001, 8'hA0);
        drive(6'b000010, 8'h21);
        drive(6'b000100, 8'hAA);
        exp_q.push_back(8'h2B);
        lines = 6'b001000;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (io_out[5]) found = 1'b1;
        end
        lat = 0;
        found = 1'b0;
        for (int i = 1; i <= 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (io_out[4]) begin
                found = 1'b1;
                lat = i;
            end
        end
        check_int("dwell_timeout", lat, TB_MAX_DWELL + 1);
        check("dwell_error_out", io_out, 8'h53);
        do_reset();
`endif

        step(5);
        check_int("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
